// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_sched block.
//   state_t : scheduling controller states
//   MIN_DIV : smallest divide ratio that produces a well-formed period
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_sched_cnt.sv
// Period counter for clk_div_sched. Counts 0..div-1 and wraps.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : advance the counter this cycle
//   clr      : force the counter to zero (wins over en)
//   div      : ratio currently in force
//   cnt      : current position inside the period
//   wrap     : cnt is on the last cycle of the period
module clk_div_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    assign wrap = (cnt == (div - CNT_W'(1)));

    // cnt < div <= 2^CNT_W-1, so the increment never overflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Programmable clock-enable divider with period-boundary scheduling.
// Emits a one-cycle tick on the last cycle of each period plus a divided
// phase waveform. Ratio changes arrive over a valid/ready handshake and are
// applied only at a period boundary.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   run       : level, 1 = generate periods, 0 = stop at next boundary
//   cfg_div   : requested ratio, cfg_valid/cfg_ready handshake
//   cfg_err   : one-cycle pulse, accepted request had cfg_div < MIN_DIV
//   tick      : last cycle of each period
//   phase     : high for the first floor(div/2) cycles of each period
//   cur_div   : ratio in force
//   busy      : controller not idle
//
// state | meaning
// IDLE  | counter held at 0, no ticks; ratio may be rewritten directly
// RUN   | periods generated; requests accepted
// PEND  | new ratio latched, old period finishing; no requests accepted
// STOP  | run dropped, current period finishing; run=1 resumes seamlessly
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             phase,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             accept;
    logic             div_ok;
    logic             cnt_en;
    logic             cnt_clr;

    assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
    assign accept    = cfg_valid && cfg_ready;
    assign div_ok    = (cfg_div >= CNT_W'(MIN_DIV));

    // IDLE parks the counter at zero so RUN always starts a fresh period.
    assign cnt_clr = (state_q == IDLE);
    assign cnt_en  = (state_q != IDLE);

    clk_div_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .div  (div_q),
        .cnt  (cnt),
        .wrap (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= CNT_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        cfg_err_d  = accept && !div_ok;

        case (state_q)
            IDLE: begin
                if (accept && div_ok) begin
                    div_d = cfg_div;
                end
                if (run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A latched request takes priority over run=0; PEND's wrap
                // handling then decides between RUN and IDLE.
                if (accept && div_ok) begin
                    pend_div_d = cfg_div;
                    state_d    = PEND;
                end else if (!run) begin
                    state_d = STOP;
                end
            end
            PEND: begin
                if (wrap) begin
                    div_d   = pend_div_q;
                    state_d = run ? RUN : IDLE;
                end
            end
            STOP: begin
                // run wins on the wrap cycle too, so re-raising run never
                // inserts a dead cycle between periods.
                if (run) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign tick    = busy && wrap;
    assign phase   = busy && (cnt < (div_q >> 1));
    assign cur_div = div_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
module tb_clk_div_sched;

    localparam int CNT_W = 8;
    localparam int DEF   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic             tick;
    logic             phase;
    logic [CNT_W-1:0] cur_div;
    logic             busy;

    clk_div_sched #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .phase     (phase),
        .cur_div   (cur_div),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural reference: "generating" flag, finishing-because-stopped flag,
    // finishing-because-ratio-pending flag, position in period, ratios.
    bit m_active, m_stopping, m_pending, m_err, m_acc;
    int m_cnt, m_div, m_pend;

    // {tick, phase, busy, cfg_ready, cfg_err, cur_div}
    logic [12:0] exp_q[$];

    function automatic logic [12:0] model_out();
        bit t, p, rdy;
        t   = m_active && (m_cnt == m_div - 1);
        p   = m_active && (m_cnt < m_div / 2);
        rdy = !m_active || (!m_stopping && !m_pending);
        return {t, p, m_active, rdy, m_err, 8'(m_div)};
    endfunction

    task automatic model_reset();
        m_active = 0; m_stopping = 0; m_pending = 0; m_err = 0;
        m_cnt = 0; m_div = DEF; m_pend = 0; m_acc = 0;
    endtask

    task automatic model_step(input bit r, input bit rn, input bit v, input int d);
        bit rdy, last, good;
        if (r) begin
            model_reset();
            return;
        end
        rdy   = !m_active || (!m_stopping && !m_pending);
        m_acc = v && rdy;
        good  = m_acc && (d >= 2);
        m_err = m_acc && (d < 2);
        last  = m_active && (m_cnt == m_div - 1);
        if (!m_active) begin
            if (good) m_div = d;
            m_cnt = 0;
            if (rn) m_active = 1;
        end else begin
            m_cnt = last ? 0 : m_cnt + 1;
            if (m_pending) begin
                if (last) begin
                    m_div = m_pend;
                    m_pending = 0;
                    if (!rn) m_active = 0;
                end
            end else if (m_stopping) begin
                if (rn) m_stopping = 0;
                else if (last) begin
                    m_stopping = 0;
                    m_active = 0;
                end
            end else begin
                if (good) begin
                    m_pend = d;
                    m_pending = 1;
                end else if (!rn) m_stopping = 1;
            end
        end
    endtask

    // One cycle: record what the DUT must show now, then apply new inputs.
    task automatic drive(input bit r, input bit rn, input bit v, input int d);
        @(negedge clk);
        exp_q.push_back(model_out());
        rst = r; run = rn; cfg_valid = v; cfg_div = 8'(d);
        model_step(r, rn, v, d);
        cyc++;
    endtask

    // Issue a request until accepted, bounded.
    task automatic request(input bit rn, input int d);
        int k = 0;
        m_acc = 0;
        while (!m_acc && k < 64) begin
            drive(0, rn, 1, d);
            k++;
        end
        if (!m_acc) begin
            n_tests++; n_fail++;
            $display("FAIL request_timeout div=%0d accepted=0 required=1", d);
        end
    endtask

    task automatic idle_cycles(input int n, input bit rn);
        for (int i = 0; i < n; i++) drive(0, rn, 0, 0);
    endtask

    // Monitor / scoreboard.
    initial begin
        logic [12:0] e, a;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {tick, phase, busy, cfg_ready, cfg_err, cur_div};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t tick/phase/busy/rdy/err act=%b%b%b%b%b div=%0d exp=%b%b%b%b%b div=%0d",
                             $time, a[12], a[11], a[10], a[9], a[8], a[7:0],
                             e[12], e[11], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        bit hv;
        int hd, k;
        rst = 1; run = 0; cfg_valid = 0; cfg_div = '0;
        repeat (2) @(posedge clk);
        model_reset();

        drive(1, 0, 0, 0);                 // reset values checked here
        idle_cycles(2, 0);
        idle_cycles(10, 1);                // div=3 ticks, phase 1,0,0
        request(1, 1);                     // rejected, err pulse
        idle_cycles(7, 1);
        k = 0;
        while (m_cnt != 1 && k < 10) begin drive(0, 1, 0, 0); k++; end
        request(1, 5);                     // mid-period switch to 5
        idle_cycles(14, 1);
        request(1, 4);
        idle_cycles(6, 1);
        k = 0;
        while (!(m_active && !m_pending && m_cnt == 1) && k < 20) begin drive(0, 1, 0, 0); k++; end
        idle_cycles(6, 0);                 // stop at cnt=1, one more tick
        idle_cycles(5, 1);
        drive(0, 0, 0, 0);                 // enter STOP, then resume
        idle_cycles(9, 1);
        request(0, 6);                     // accept + drop run same cycle
        idle_cycles(8, 0);
        idle_cycles(14, 1);
        request(1, 9);                     // PEND, then reset
        drive(1, 1, 0, 0);
        idle_cycles(3, 0);
        idle_cycles(8, 1);

        hv = 0; hd = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, rn;
            if (!hv && ($urandom % 4 == 0)) begin
                hv = 1;
                hd = ($urandom % 3 == 0) ? int'($urandom % 3) : int'($urandom_range(2, 11));
            end
            r  = ($urandom % 300 == 0);
            rn = ($urandom % 8 != 0);
            drive(r, rn, hv, hv ? hd : int'($urandom % 12));
            if (m_acc || r) hv = 0;
        end

        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired=1 required=0");
        $fatal(1, "watchdog");
    end

endmodule
